// File: rtl/pqc_pkg.sv
// Shared constants and types for the PQC accelerator issue controller.
package pqc_pkg;

  localparam logic [6:0] PQC_OPCODE = 7'b0001011;
  localparam logic [2:0] PQC_FUNCT3 = 3'b011;

  localparam logic [6:0] F7_NTT_A   = 7'b0000011;
  localparam logic [6:0] F7_NTT_B   = 7'b0000100;
  localparam logic [6:0] F7_PWAM_M0 = 7'b0000111;
  localparam logic [6:0] F7_PWAM_M1 = 7'b0000101;
  localparam logic [6:0] F7_KECCAK  = 7'b0000000;

  typedef enum logic [1:0] {
    UNIT_NONE   = 2'd0,
    UNIT_NTT    = 2'd1,
    UNIT_PWAM   = 2'd2,
    UNIT_KECCAK = 2'd3
  } unit_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RETIRE = 2'd3
  } state_e;

endpackage

// File: rtl/pqc_op_decode.sv
// Combinational decode of a custom-0 instruction into accelerator unit and mode.
module pqc_op_decode
  import pqc_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic       is_pqc_o,
  output unit_e      unit_o,
  output logic       mode_o,
  output logic       illegal_o
);

  logic match;
  logic unknown;

  assign match = (opcode_i == PQC_OPCODE) && (funct3_i == PQC_FUNCT3);

  always_comb begin
    unit_o  = UNIT_NONE;
    mode_o  = 1'b0;
    unknown = 1'b0;
    case (funct7_i)
      F7_NTT_A, F7_NTT_B: unit_o = UNIT_NTT;
      F7_PWAM_M0:         unit_o = UNIT_PWAM;
      F7_PWAM_M1: begin
        unit_o = UNIT_PWAM;
        mode_o = 1'b1;
      end
      F7_KECCAK:          unit_o = UNIT_KECCAK;
      default:            unknown = 1'b1;
    endcase
  end

  assign is_pqc_o  = match;
  assign illegal_o = match & unknown;

endmodule

// File: rtl/pqc_accel_ctrl.sv
// Issue/retire controller for the NTT, PWAM and Keccak accelerators: freezes the
// pipeline while one op is in flight and forces retirement through a watchdog.
module pqc_accel_ctrl
  import pqc_pkg::*;
#(
  parameter int unsigned           TIMEOUT_W      = 16,
  parameter logic [TIMEOUT_W-1:0]  TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic       flush,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       ntt_done,
  input  logic       pwam_done,
  input  logic       keccak_done,
  output logic       ntt_start,
  output logic       pwam_start,
  output logic       pwam_mode,
  output logic       keccak_start,
  output logic       pqc_stall,
  output logic       retire,
  output logic       illegal,
  output logic       timeout,
  output logic [1:0] busy_unit
);

  logic  dec_is_pqc;
  unit_e dec_unit;
  logic  dec_mode;
  logic  dec_illegal;

  pqc_op_decode u_decode (
    .opcode_i  (opcode),
    .funct3_i  (funct3),
    .funct7_i  (funct7),
    .is_pqc_o  (dec_is_pqc),
    .unit_o    (dec_unit),
    .mode_o    (dec_mode),
    .illegal_o (dec_illegal)
  );

  state_e                 state_q, state_d;
  unit_e                  unit_q, unit_d;
  logic                   mode_q, mode_d;
  logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
  logic                   timeout_q, timeout_d;

  logic                   in_idle, in_flight;
  logic                   op_valid, op_legal;
  logic                   sel_done;
  logic [TIMEOUT_W-1:0]   cnt_sat;

  assign in_idle   = (state_q == ST_IDLE);
  assign in_flight = (state_q == ST_START) || (state_q == ST_WAIT);
  assign op_valid  = instr_valid & ~flush & dec_is_pqc;
  assign op_legal  = op_valid & ~dec_illegal;
  assign cnt_sat   = (&cnt_q) ? cnt_q : cnt_q + TIMEOUT_W'(1);

  // Only the latched unit's completion is honoured; stray pulses from idle units are dropped.
  always_comb begin
    sel_done = 1'b0;
    case (unit_q)
      UNIT_NTT:    sel_done = ntt_done;
      UNIT_PWAM:   sel_done = pwam_done;
      UNIT_KECCAK: sel_done = keccak_done;
      default:     sel_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      unit_q    <= UNIT_NONE;
      mode_q    <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      unit_q    <= unit_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    unit_d    = unit_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (op_legal) begin
          unit_d    = dec_unit;
          mode_d    = dec_mode;
          cnt_d     = '0;
          timeout_d = 1'b0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        state_d = sel_done ? ST_RETIRE : ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_sat;
        if (sel_done) begin
          state_d = ST_RETIRE;
        end else if (cnt_sat >= TIMEOUT_CYCLES) begin
          timeout_d = 1'b1;
          state_d   = ST_RETIRE;
        end
      end
      ST_RETIRE: begin
        unit_d  = UNIT_NONE;
        mode_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ntt_start    = (state_q == ST_START) && (unit_q == UNIT_NTT);
  assign pwam_start   = (state_q == ST_START) && (unit_q == UNIT_PWAM);
  assign keccak_start = (state_q == ST_START) && (unit_q == UNIT_KECCAK);
  assign retire       = (state_q == ST_RETIRE);
  assign illegal      = in_idle & op_valid & dec_illegal;
  // Stall drops in RETIRE so the frozen instruction advances exactly once.
  assign pqc_stall    = (in_idle & op_legal) | in_flight;
  assign busy_unit    = in_flight ? unit_q : UNIT_NONE;
  assign pwam_mode    = mode_q;
  assign timeout      = timeout_q;

endmodule
